// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle for alu_arbiter.
//   req0_* / req1_* : two valid/ready request channels (operands a, b and 3-bit op)
//   resp_*          : single tagged response channel with backpressure
//   flags0/flags1   : last legal {Z,N,C,V} delivered to each requester
// Modports: master = requesters/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic [3:0]       resp_flags;
  logic             resp_err;
  logic [3:0]       flags0;
  logic [3:0]       flags1;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_result, resp_flags, resp_err,
    input  flags0, flags1
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_result, resp_flags, resp_err,
    output flags0, flags1
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters using
// round-robin arbitration. A request is latched in IDLE, executed in EXEC and
// returned in RESP, where it is held until the consumer accepts it.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_arbiter_if.slave (request channels, response channel, flags)
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic [3:0]       resp_flags_q, resp_flags_d;
  logic             resp_err_q, resp_err_d;
  logic [3:0]       flags0_q, flags0_d;
  logic [3:0]       flags1_q, flags1_d;

  logic             grant_s;
  logic             ready0_s;
  logic             ready1_s;
  logic             sub_s;
  logic [WIDTH:0]   sum_s;
  logic             ovf_s;
  logic             carry_s;
  logic             alu_err_s;
  logic [WIDTH-1:0] alu_res_s;
  logic [3:0]       alu_flags_s;

  // ALU on the latched operands; sub and slt share the adder as a + ~b + 1
  always_comb begin
    sub_s     = (op_q != OP_ADD);
    sum_s     = {1'b0, op_a_q} + {1'b0, (sub_s ? ~op_b_q : op_b_q)}
              + {{WIDTH{1'b0}}, sub_s};
    // Overflow: operand signs (after b inversion for subtract) agree, result sign differs
    if (sub_s) begin
      ovf_s = (op_a_q[WIDTH-1] != op_b_q[WIDTH-1]) && (sum_s[WIDTH-1] != op_a_q[WIDTH-1]);
    end else begin
      ovf_s = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (sum_s[WIDTH-1] != op_a_q[WIDTH-1]);
    end
    alu_res_s = '0;
    carry_s   = 1'b0;
    alu_err_s = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res_s = sum_s[WIDTH-1:0];
        carry_s   = sum_s[WIDTH];
      end
      OP_AND: alu_res_s = op_a_q & op_b_q;
      OP_OR:  alu_res_s = op_a_q | op_b_q;
      OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_s};
      default: alu_err_s = 1'b1;
    endcase
    if (alu_err_s) begin
      alu_flags_s = 4'b0000;
    end else begin
      // V only has meaning for the adder-based ops
      alu_flags_s = {(alu_res_s == '0), alu_res_s[WIDTH-1], carry_s,
                     ovf_s & ((op_q == OP_ADD) | (op_q == OP_SUB) | (op_q == OP_SLT))};
    end
  end

  // Arbitration, next-state and register next values
  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_d          = op_q;
    id_d          = id_q;
    last_grant_d  = last_grant_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    resp_err_d    = resp_err_q;
    flags0_d      = flags0_q;
    flags1_d      = flags1_q;
    ready0_s      = 1'b0;
    ready1_s      = 1'b0;

    // Tie goes to whoever did not win last time
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Ready goes only to a valid winner, so handshake == any valid
        if (bus.req0_valid || bus.req1_valid) begin
          ready0_s     = ~grant_s;
          ready1_s     = grant_s;
          op_a_d       = grant_s ? bus.req1_a  : bus.req0_a;
          op_b_d       = grant_s ? bus.req1_b  : bus.req0_b;
          op_d         = grant_s ? bus.req1_op : bus.req0_op;
          id_d         = grant_s;
          last_grant_d = grant_s;
          state_d      = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        resp_id_d     = id_q;
        resp_result_d = alu_res_s;
        resp_flags_d  = alu_flags_s;
        resp_err_d    = alu_err_s;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
          if (!resp_err_q) begin
            if (resp_id_q) begin
              flags1_d = resp_flags_q;
            end else begin
              flags0_d = resp_flags_q;
            end
          end else begin
            flags0_d = flags0_q;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_q          <= 3'b000;
      id_q          <= 1'b0;
      last_grant_q  <= 1'b1;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= 4'b0000;
      resp_err_q    <= 1'b0;
      flags0_q      <= 4'b0000;
      flags1_q      <= 4'b0000;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_q          <= op_d;
      id_q          <= id_d;
      last_grant_q  <= last_grant_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      resp_err_q    <= resp_err_d;
      flags0_q      <= flags0_d;
      flags1_q      <= flags1_d;
    end
  end

  // Ready is forced low while reset is held even though state already reads IDLE
  assign bus.req0_ready  = ready0_s & rst_n;
  assign bus.req1_ready  = ready1_s & rst_n;
  assign bus.resp_valid  = (state_q == ST_RESP);
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_flags  = resp_flags_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.flags0      = flags0_q;
  assign bus.flags1      = flags1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter.
// Drives inputs on the falling edge and samples outputs away from the rising edge.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [3:0] exp_flags0;
  logic [3:0] exp_flags1;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete operation from a negedge; resp_ready held low for 'stall' cycles in RESP
  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] er, input logic [3:0] ef,
                        input logic ee, input int stall);
    int   n;
    logic rdy;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
    #1;
    n   = 0;
    rdy = id ? bus.req1_ready : bus.req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1;
      rdy = id ? bus.req1_ready : bus.req0_ready;
      n++;
    end
    check("grant", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("exec_no_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    check("resp_valid", 32'(bus.resp_valid), 32'd1);
    check("resp_id", 32'(bus.resp_id), 32'(id));
    check("resp_result", bus.resp_result, er);
    check("resp_flags", 32'(bus.resp_flags), 32'(ef));
    check("resp_err", 32'(bus.resp_err), 32'(ee));
    if (stall > 0) begin
      bus.resp_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("stall_valid", 32'(bus.resp_valid), 32'd1);
        check("stall_result", bus.resp_result, er);
        check("stall_id", 32'(bus.resp_id), 32'(id));
        check("stall_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
      end
      bus.resp_ready = 1'b1;
    end
    if (!ee) begin
      if (id) exp_flags1 = ef;
      else    exp_flags0 = ef;
    end
    @(negedge clk);
    check("resp_done", 32'(bus.resp_valid), 32'd0);
    check("flags0", 32'(bus.flags0), 32'(exp_flags0));
    check("flags1", 32'(bus.flags1), 32'(exp_flags1));
  endtask

  initial begin
    int ng;
    int n;
    int last_n;
    checks = 0; errors = 0;
    exp_flags0 = 4'b0000; exp_flags1 = 4'b0000;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_op = 3'b000;
    bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_op = 3'b000;
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_result", bus.resp_result, 32'd0);
    check("rst_flags", {24'd0, bus.flags0, bus.flags1}, 32'd0);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'd5, 32'd3, 3'b000, 32'd8, 4'b0000, 1'b0, 0);
    run_op(1'b1, 32'h0000F0F0, 32'h0000FF00, 3'b010, 32'h0000F000, 4'b0000, 1'b0, 0);
    run_op(1'b1, 32'h00000000, 32'h00000000, 3'b011, 32'h00000000, 4'b1000, 1'b0, 0);
    run_op(1'b1, 32'd3, 32'd5, 3'b001, 32'hFFFFFFFE, 4'b0100, 1'b0, 0);
    run_op(1'b1, 32'd5, 32'd5, 3'b001, 32'd0, 4'b1010, 1'b0, 0);
    run_op(1'b0, 32'h7FFFFFFF, 32'd1, 3'b000, 32'h80000000, 4'b0101, 1'b0, 0);
    run_op(1'b0, 32'h80000000, 32'd1, 3'b101, 32'd1, 4'b0001, 1'b0, 0);
    run_op(1'b0, 32'd7, 32'd3, 3'b101, 32'd0, 4'b1000, 1'b0, 0);
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, 3'b000, 32'd0, 4'b1010, 1'b0, 0);
    run_op(1'b1, 32'd9, 32'd4, 3'b110, 32'd0, 4'b0000, 1'b1, 0);
    run_op(1'b1, 32'd9, 32'd4, 3'b100, 32'd0, 4'b0000, 1'b1, 0);
    run_op(1'b1, 32'd9, 32'd4, 3'b111, 32'd0, 4'b0000, 1'b1, 0);
    run_op(1'b0, 32'd1, 32'd2, 3'b000, 32'd3, 4'b0000, 1'b0, 5);
    run_op(1'b0, 32'd0, 32'd0, 3'b000, 32'd0, 4'b1000, 1'b0, 0);

    // Reset while an operation is in EXEC
    bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_op = 3'b000;
    #1;
    check("pre_rst_ready0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_exec_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_exec_flags", {24'd0, bus.flags0, bus.flags1}, 32'd0);
    check("rst_exec_resp", {bus.resp_result[27:0], bus.resp_flags}, 32'd0);
    check("rst_exec_misc", {29'd0, bus.resp_id, bus.resp_err, bus.req0_ready | bus.req1_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_resp_after_rst", 32'(bus.resp_valid), 32'd0);
    end

    // Both requesters continuously valid: grants alternate starting with 0, one every 3 cycles
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_op = 3'b000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd2; bus.req1_b = 32'd2; bus.req1_op = 3'b000;
    #1;
    ng = 0; n = 0; last_n = 0;
    while (ng < 4 && n < 60) begin
      check("one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      if (bus.req0_ready | bus.req1_ready) begin
        check("grant_order", 32'(bus.req1_ready), 32'(ng % 2));
        if (ng > 0) check("grant_gap", 32'(n - last_n), 32'd3);
        last_n = n;
        ng++;
      end
      @(negedge clk); #1;
      n++;
    end
    check("grant_count", 32'(ng), 32'd4);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
